// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared types, sizes and key byte helper for the ARC4 encryptor
package arc4_pkg;

  localparam int KEY_BYTES = 3;
  localparam int KEY_W     = 8 * KEY_BYTES;
  localparam int S_SIZE    = 256;

  localparam logic [1:0] KIDX_LAST = 2'(KEY_BYTES - 1);

  // Top-level sequencer states; INIT and KSA run inside arc4_ksched while the
  // top sits in ST_KSCHED.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KSCHED,
    ST_LEN_WAIT,
    ST_LEN_RD,
    ST_LEN_WR,
    ST_PRGA_I,
    ST_PRGA_IW,
    ST_PRGA_IR,
    ST_PRGA_JW,
    ST_PRGA_JR,
    ST_PRGA_WJ,
    ST_PRGA_WI,
    ST_PRGA_PW,
    ST_PRGA_PR,
    ST_PRGA_CT,
    ST_DONE
  } arc4_state_e;

  // Key schedule states: INIT fill, then read S[i], read S[j], write both back.
  typedef enum logic [2:0] {
    KS_IDLE,
    KS_INIT,
    KS_KSA_IW,
    KS_KSA_IR,
    KS_KSA_JW,
    KS_KSA_JR,
    KS_KSA_WJ,
    KS_KSA_WI
  } ks_state_e;

  // Key byte idx, counted MSB-first: idx 0 is key[KEY_W-1 -: 8].
  function automatic logic [7:0] keybyte(input logic [KEY_W-1:0] key, input logic [1:0] idx);
    return key[8 * (KEY_BYTES - 1 - int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/arc4_ksched.sv
// rtl/arc4_ksched.sv - S identity fill followed by the ARC4 key schedule
module arc4_ksched
  import arc4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic             o_rdy,
  input  logic [KEY_W-1:0] i_key,
  output logic [7:0]       o_s_addr,
  input  logic [7:0]       i_s_rddata,
  output logic [7:0]       o_s_wrdata,
  output logic             o_s_wren
);

  ks_state_e        r_state;
  logic             r_rdy;
  logic [KEY_W-1:0] r_key;
  logic [7:0]       r_i;
  logic [7:0]       r_j;
  logic [1:0]       r_kidx;
  logic [7:0]       r_si;
  logic [7:0]       r_sj;
  logic [7:0]       r_s_addr;
  logic [7:0]       r_s_wrdata;
  logic             r_s_wren;
  logic [7:0]       w_j_new;

  assign w_j_new    = r_j + i_s_rddata + keybyte(r_key, r_kidx);
  assign o_rdy      = r_rdy;
  assign o_s_addr   = r_s_addr;
  assign o_s_wrdata = r_s_wrdata;
  assign o_s_wren   = r_s_wren;

  // Sequencer: 256 fill writes, then 6 cycles per i (read S[i], read S[j], write S[j], write S[i]).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= KS_IDLE;
      r_rdy      <= 1'b1;
      r_key      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_kidx     <= '0;
      r_si       <= '0;
      r_sj       <= '0;
      r_s_addr   <= '0;
      r_s_wrdata <= '0;
      r_s_wren   <= 1'b0;
    end else begin
      case (r_state)
        KS_IDLE: begin
          if (i_en && r_rdy) begin
            r_rdy      <= 1'b0;
            r_key      <= i_key;
            r_i        <= '0;
            r_s_addr   <= '0;
            r_s_wrdata <= '0;
            r_s_wren   <= 1'b1;
            r_state    <= KS_INIT;
          end
        end
        KS_INIT: begin
          if (r_i == 8'd255) begin
            r_i      <= '0;
            r_j      <= '0;
            r_kidx   <= '0;
            r_s_addr <= '0;
            r_s_wren <= 1'b0;
            r_state  <= KS_KSA_IW;
          end else begin
            r_i        <= r_i + 8'd1;
            r_s_addr   <= r_i + 8'd1;
            r_s_wrdata <= r_i + 8'd1;
          end
        end
        KS_KSA_IW: r_state <= KS_KSA_IR;
        KS_KSA_IR: begin
          r_si     <= i_s_rddata;
          r_j      <= w_j_new;
          r_s_addr <= w_j_new;
          r_state  <= KS_KSA_JW;
        end
        KS_KSA_JW: r_state <= KS_KSA_JR;
        KS_KSA_JR: begin
          // Both values are held before either write, so i == j is a no-op swap.
          r_sj       <= i_s_rddata;
          r_s_addr   <= r_j;
          r_s_wrdata <= r_si;
          r_s_wren   <= 1'b1;
          r_state    <= KS_KSA_WJ;
        end
        KS_KSA_WJ: begin
          r_s_addr   <= r_i;
          r_s_wrdata <= r_sj;
          r_state    <= KS_KSA_WI;
        end
        KS_KSA_WI: begin
          r_s_wren <= 1'b0;
          if (r_i == 8'd255) begin
            r_s_addr   <= '0;
            r_s_wrdata <= '0;
            r_rdy      <= 1'b1;
            r_state    <= KS_IDLE;
          end else begin
            r_i      <= r_i + 8'd1;
            r_kidx   <= (r_kidx == KIDX_LAST) ? 2'd0 : r_kidx + 2'd1;
            r_s_addr <= r_i + 8'd1;
            r_state  <= KS_KSA_IW;
          end
        end
        default: r_state <= KS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arc4_encrypt.sv
// rtl/arc4_encrypt.sv - ARC4 encryptor: key schedule, length copy and PRGA over external memories
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic [7:0]       s_addr,
  input  logic [7:0]       s_rddata,
  output logic [7:0]       s_wrdata,
  output logic             s_wren,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata,
  output logic [7:0]       ct_addr,
  output logic [7:0]       ct_wrdata,
  output logic             ct_wren
);

  arc4_state_e r_state;
  logic        r_rdy;
  logic [7:0]  r_len;
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [8:0]  r_k;
  logic [7:0]  r_si;
  logic [7:0]  r_sj;
  logic [7:0]  r_pt;
  logic [7:0]  r_s_addr;
  logic [7:0]  r_s_wrdata;
  logic        r_s_wren;
  logic [7:0]  r_pt_addr;
  logic [7:0]  r_ct_addr;
  logic [7:0]  r_ct_wrdata;
  logic        r_ct_wren;

  logic        w_start;
  logic        w_ks_sel;
  logic        w_ks_rdy;
  logic [7:0]  w_ks_s_addr;
  logic [7:0]  w_ks_s_wrdata;
  logic        w_ks_s_wren;
  logic [7:0]  w_j_new;

  assign w_start  = en && r_rdy && (r_state == ST_IDLE);
  assign w_ks_sel = (r_state == ST_KSCHED);
  assign w_j_new  = r_j + s_rddata;

  arc4_ksched u_ksched (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_start),
    .o_rdy      (w_ks_rdy),
    .i_key      (key),
    .o_s_addr   (w_ks_s_addr),
    .i_s_rddata (s_rddata),
    .o_s_wrdata (w_ks_s_wrdata),
    .o_s_wren   (w_ks_s_wren)
  );

  assign rdy       = r_rdy;
  assign s_addr    = w_ks_sel ? w_ks_s_addr   : r_s_addr;
  assign s_wrdata  = w_ks_sel ? w_ks_s_wrdata : r_s_wrdata;
  assign s_wren    = w_ks_sel ? w_ks_s_wren   : r_s_wren;
  assign pt_addr   = r_pt_addr;
  assign ct_addr   = r_ct_addr;
  assign ct_wrdata = r_ct_wrdata;
  assign ct_wren   = r_ct_wren;

  // Main sequencer: hand off INIT/KSA, copy the length byte, then 10 cycles per PRGA byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rdy       <= 1'b1;
      r_len       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_si        <= '0;
      r_sj        <= '0;
      r_pt        <= '0;
      r_s_addr    <= '0;
      r_s_wrdata  <= '0;
      r_s_wren    <= 1'b0;
      r_pt_addr   <= '0;
      r_ct_addr   <= '0;
      r_ct_wrdata <= '0;
      r_ct_wren   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_rdy   <= 1'b0;
            r_state <= ST_KSCHED;
          end
        end
        ST_KSCHED: begin
          if (w_ks_rdy) begin
            r_pt_addr <= '0;
            r_state   <= ST_LEN_WAIT;
          end
        end
        ST_LEN_WAIT: r_state <= ST_LEN_RD;
        ST_LEN_RD: begin
          r_len       <= pt_rddata;
          r_ct_addr   <= '0;
          r_ct_wrdata <= pt_rddata;
          r_ct_wren   <= 1'b1;
          r_i         <= '0;
          r_j         <= '0;
          r_k         <= 9'd1;
          r_state     <= ST_LEN_WR;
        end
        ST_LEN_WR: begin
          r_ct_wren <= 1'b0;
          r_state   <= (r_len == 8'd0) ? ST_DONE : ST_PRGA_I;
        end
        ST_PRGA_I: begin
          // pt[k] is fetched alongside S[i]; the two memories are independent.
          r_i       <= r_i + 8'd1;
          r_s_addr  <= r_i + 8'd1;
          r_pt_addr <= r_k[7:0];
          r_state   <= ST_PRGA_IW;
        end
        ST_PRGA_IW: r_state <= ST_PRGA_IR;
        ST_PRGA_IR: begin
          r_si     <= s_rddata;
          r_pt     <= pt_rddata;
          r_j      <= w_j_new;
          r_s_addr <= w_j_new;
          r_state  <= ST_PRGA_JW;
        end
        ST_PRGA_JW: r_state <= ST_PRGA_JR;
        ST_PRGA_JR: begin
          r_sj       <= s_rddata;
          r_s_addr   <= r_j;
          r_s_wrdata <= r_si;
          r_s_wren   <= 1'b1;
          r_state    <= ST_PRGA_WJ;
        end
        ST_PRGA_WJ: begin
          r_s_addr   <= r_i;
          r_s_wrdata <= r_sj;
          r_state    <= ST_PRGA_WI;
        end
        ST_PRGA_WI: begin
          // Swap leaves the same pair in S, so the pad index is unchanged by it.
          r_s_wren <= 1'b0;
          r_s_addr <= r_si + r_sj;
          r_state  <= ST_PRGA_PW;
        end
        ST_PRGA_PW: r_state <= ST_PRGA_PR;
        ST_PRGA_PR: begin
          r_ct_addr   <= r_k[7:0];
          r_ct_wrdata <= r_pt ^ s_rddata;
          r_ct_wren   <= 1'b1;
          r_state     <= ST_PRGA_CT;
        end
        ST_PRGA_CT: begin
          r_ct_wren <= 1'b0;
          if (r_k == {1'b0, r_len}) begin
            r_state <= ST_DONE;
          end else begin
            r_k     <= r_k + 9'd1;
            r_state <= ST_PRGA_I;
          end
        end
        ST_DONE: begin
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb/tb_arc4_encrypt.sv - directed self-checking bench for arc4_encrypt
module tb_arc4_encrypt;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;

  logic [7:0] s_mem  [0:255];
  logic [7:0] pt_mem [0:255];
  logic [7:0] ct_mem [0:255];
  logic [7:0] m_s    [0:255];
  logic [7:0] m_ct   [0:255];

  int n_chk;
  int n_fail;
  int ct_cnt;
  int ct_ord_err;
  int idle_wren_err;
  int cyc;

  arc4_encrypt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  // ct write count/order per operation, and wren while idle
  always @(posedge clk) begin
    if (rst_n && en && rdy) begin
      ct_cnt     <= 0;
      ct_ord_err <= 0;
    end else if (ct_wren) begin
      if (ct_addr != ct_cnt[7:0]) ct_ord_err <= ct_ord_err + 1;
      ct_cnt <= ct_cnt + 1;
    end
    if (rst_n && rdy && (s_wren || ct_wren)) idle_wren_err <= idle_wren_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ARC4 over pt_mem
  task automatic model(input logic [23:0] kk);
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] ii;
    logic [7:0] len;
    for (int n = 0; n < 256; n++) m_s[n] = n[7:0];
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      j = j + m_s[n] + kk[8 * (2 - (n % 3)) +: 8];
      t = m_s[n]; m_s[n] = m_s[j]; m_s[j] = t;
    end
    len = pt_mem[0];
    m_ct[0] = len;
    ii = 8'd0;
    j = 8'd0;
    for (int n = 1; n <= int'(len); n++) begin
      ii = ii + 8'd1;
      j = j + m_s[ii];
      t = m_s[ii]; m_s[ii] = m_s[j]; m_s[j] = t;
      t = m_s[ii] + m_s[j];
      m_ct[n] = pt_mem[n] ^ m_s[t];
    end
  endtask

  task automatic start_op(input logic [23:0] k);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
  endtask

  task automatic wait_rdy(input string tag, input int limit, output int c);
    c = 1;
    while (rdy !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk({tag, " rdy"}, {31'd0, rdy}, 32'd1);
  endtask

  task automatic check_result(input string tag, input int len, input int bound, input int c);
    int bad;
    bad = 0;
    for (int n = 0; n <= len; n++) if (ct_mem[n] !== m_ct[n]) bad++;
    chk({tag, " ct bytes"}, bad, 0);
    chk({tag, " ct writes"}, ct_cnt, len + 1);
    chk({tag, " ct order"}, ct_ord_err, 0);
    chk({tag, " cycle bound"}, {31'd0, c <= bound}, 32'd1);
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) bad++;
    chk({tag, " S state"}, bad, 0);
  endtask

  task automatic load_std();
    logic [7:0] msg [0:9];
    msg = '{8'd9, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int n = 0; n < 10; n++) pt_mem[n] = msg[n];
  endtask

  task automatic check_std(input string tag, input int c);
    logic [7:0] exp_ct [0:9];
    int bad;
    exp_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    bad = 0;
    for (int n = 0; n < 10; n++) if (ct_mem[n] !== exp_ct[n]) bad++;
    chk({tag, " known ct"}, bad, 0);
    chk({tag, " ct[1]"}, {24'd0, ct_mem[1]}, 32'hBB);
    chk({tag, " ct writes"}, ct_cnt, 10);
    chk({tag, " ct order"}, ct_ord_err, 0);
    chk({tag, " cycle bound"}, {31'd0, c <= 2400}, 32'd1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    ct_cnt = 0; ct_ord_err = 0; idle_wren_err = 0;
    rst_n = 1'b0; en = 1'b0; key = 24'd0;
    for (int n = 0; n < 256; n++) begin
      pt_mem[n] = 8'd0; s_mem[n] = 8'd0; ct_mem[n] = 8'd0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset rdy", {31'd0, rdy}, 32'd1);
    chk("reset s_wren", {31'd0, s_wren}, 32'd0);
    chk("reset ct_wren", {31'd0, ct_wren}, 32'd0);
    chk("reset addrs", {s_addr, pt_addr, ct_addr, 8'd0}, 32'd0);
    chk("reset data", {16'd0, s_wrdata, ct_wrdata}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Standard vector
    load_std();
    start_op(24'h4B6579);
    wait_rdy("std", 3000, cyc);
    check_std("std", cyc);

    // Empty message: ct[0]=0 only, S holds KSA result
    pt_mem[0] = 8'd0;
    model(24'h000000);
    start_op(24'h000000);
    wait_rdy("empty", 3000, cyc);
    chk("empty ct[0]", {24'd0, ct_mem[0]}, 32'd0);
    check_result("empty", 0, 256 + 2048 + 4 + 2, cyc);

    // Maximum length, k must reach 255 without wrapping
    pt_mem[0] = 8'd255;
    for (int n = 1; n < 256; n++) pt_mem[n] = n[7:0];
    model(24'h1E4600);
    start_op(24'h1E4600);
    wait_rdy("max", 6000, cyc);
    chk("max ct[0]", {24'd0, ct_mem[0]}, 32'd255);
    check_result("max", 255, 256 + 2048 + 4 + 2550 + 2, cyc);
    begin
      int bad;
      bad = 0;
      for (int n = 1; n < 256; n++)
        if ((ct_mem[n] ^ m_ct[n] ^ pt_mem[n]) !== n[7:0]) bad++;
      chk("max round trip", bad, 0);
    end

    // Held en and mid-operation key change
    pt_mem[0] = 8'd5;
    for (int n = 1; n < 6; n++) pt_mem[n] = 8'hA0 + n[7:0];
    model(24'h123456);
    @(negedge clk);
    key = 24'h123456;
    en  = 1'b1;
    repeat (400) @(negedge clk);
    key = 24'hFEDCBA;
    wait_rdy("held1", 5000, cyc);
    check_result("held1", 5, 2400, cyc + 400);
    @(negedge clk);
    chk("held restart rdy", {31'd0, rdy}, 32'd0);
    en = 1'b0;
    model(24'hFEDCBA);
    wait_rdy("held2", 5000, cyc);
    check_result("held2", 5, 2400, cyc);
    repeat (5) @(negedge clk);
    chk("idle no restart", {31'd0, rdy}, 32'd1);
    chk("idle no ct writes", ct_cnt, 6);

    // Reset during KSA, then rerun standard vector
    load_std();
    start_op(24'h4B6579);
    repeat (850) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset rdy", {31'd0, rdy}, 32'd1);
    chk("midreset wren", {30'd0, s_wren, ct_wren}, 32'd0);
    chk("midreset s_addr", {24'd0, s_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(24'h4B6579);
    wait_rdy("rerun", 3000, cyc);
    check_std("rerun", cyc);

    // Back-to-back with different keys and messages
    pt_mem[0] = 8'd4;
    for (int n = 1; n < 5; n++) pt_mem[n] = 8'h11 * n[7:0];
    start_op(24'hA5A5A5);
    wait_rdy("b2b first", 3000, cyc);
    pt_mem[0] = 8'd7;
    for (int n = 1; n < 8; n++) pt_mem[n] = 8'hF0 - n[7:0];
    model(24'h010203);
    start_op(24'h010203);
    wait_rdy("b2b second", 3000, cyc);
    check_result("b2b", 7, 256 + 2048 + 4 + 70 + 2, cyc);

    chk("wren while idle", idle_wren_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
